msf_time_encoder: RTL and testbench

MSF_TIME_ENCODER -- requirements
Module: msf_time_encoder

---
 rtl/msf_time_encoder_if.sv | 36 +++
 rtl/msf_time_encoder.sv | 162 ++++++++++++++++
 tb/tb_msf_time_encoder.sv | 369 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/msf_time_encoder_if.sv
// Strobe inputs, BCD time fields and the encoded-output bundle of the MSF time encoder.
// Every strobe here is valid-only: a strobe counts in each cycle where it is high at a
// rising clock edge. There is no ready/back-pressure; the encoder accepts every strobe.
interface msf_time_encoder_if;
  logic       tick_i;
  logic       load_i;
  logic [3:0] year_h_i;
  logic [3:0] year_l_i;
  logic       month_h_i;
  logic [3:0] month_l_i;
  logic [1:0] day_h_i;
  logic [3:0] day_l_i;
  logic [2:0] dow_i;
  logic [1:0] hour_h_i;
  logic [3:0] hour_l_i;
  logic [2:0] minute_h_i;
  logic [3:0] minute_l_i;
  logic       carrier_o;
  logic [5:0] second_o;
  logic       bits_valid_o;
  logic [1:0] bits_data_o;
  logic       second_00_o;
  logic       minute_o;

  modport master (
    output tick_i, load_i, year_h_i, year_l_i, month_h_i, month_l_i, day_h_i, day_l_i,
           dow_i, hour_h_i, hour_l_i, minute_h_i, minute_l_i,
    input  carrier_o, second_o, bits_valid_o, bits_data_o, second_00_o, minute_o
  );

  modport slave (
    input  tick_i, load_i, year_h_i, year_l_i, month_h_i, month_l_i, day_h_i, day_l_i,
           dow_i, hour_h_i, hour_l_i, minute_h_i, minute_l_i,
    output carrier_o, second_o, bits_valid_o, bits_data_o, second_00_o, minute_o
  );
endinterface

// File: rtl/msf_time_encoder.sv
// MSF time-code encoder: steps 100 ms slots, emits the carrier on/off pattern and the
// per-second {B,A} bits for a BCD time frame that is reloaded or auto-incremented each minute.
module msf_time_encoder (
  input  logic              clk_i,
  input  logic              rst_ni,
  msf_time_encoder_if.slave bus,
  output logic              dbg_state_o
);

  typedef struct packed {
    logic [3:0] year_h;
    logic [3:0] year_l;
    logic       month_h;
    logic [3:0] month_l;
    logic [1:0] day_h;
    logic [3:0] day_l;
    logic [2:0] dow;
    logic [1:0] hour_h;
    logic [3:0] hour_l;
    logic [2:0] minute_h;
    logic [3:0] minute_l;
  } frame_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e      state_q;
  logic [3:0]  tenth_q, tenth_d;
  logic [5:0]  second_q, second_d;
  frame_t      active_q, active_d, pending_q, field_in;
  logic        pend_v_q;
  logic        carrier_q, carrier_d;
  logic        valid_q, s00_q, minute_q;
  logic [1:0]  data_q;
  logic        minute_start;
  logic        a_bit, b_bit;
  logic [58:0] stream;
  logic [5:0]  a_idx;

  function automatic frame_t inc_minute(input frame_t f);
    frame_t r;
    r = f;
    if (f.minute_l == 4'd9) begin
      r.minute_l = 4'd0;
      if (f.minute_h == 3'd5) begin
        r.minute_h = 3'd0;
        if (f.hour_h == 2'd2 && f.hour_l == 4'd3) begin
          r.hour_h = 2'd0;
          r.hour_l = 4'd0;
        end else if (f.hour_l == 4'd9) begin
          r.hour_l = 4'd0;
          r.hour_h = f.hour_h + 2'd1;
        end else begin
          r.hour_l = f.hour_l + 4'd1;
        end
      end else begin
        r.minute_h = f.minute_h + 3'd1;
      end
    end else begin
      r.minute_l = f.minute_l + 4'd1;
    end
    return r;
  endfunction

  assign field_in = {bus.year_h_i, bus.year_l_i, bus.month_h_i, bus.month_l_i, bus.day_h_i,
                     bus.day_l_i, bus.dow_i, bus.hour_h_i, bus.hour_l_i, bus.minute_h_i,
                     bus.minute_l_i};

  always_comb begin
    tenth_d  = tenth_q;
    second_d = second_q;
    if (state_q == ST_IDLE) begin
      tenth_d  = 4'd0;
      second_d = 6'd0;
    end else if (tenth_q == 4'd9) begin
      tenth_d  = 4'd0;
      second_d = (second_q == 6'd59) ? 6'd0 : second_q + 6'd1;
    end else begin
      tenth_d = tenth_q + 4'd1;
    end

    minute_start = bus.tick_i && (tenth_d == 4'd0) && (second_d == 6'd0);
    active_d     = pend_v_q ? pending_q : inc_minute(active_q);

    // A bits in transmission order: stream[58] is second 01, stream[0] is second 59.
    stream = {16'd0, active_q, 8'b0111_1110};
    a_idx  = 6'd59 - second_d;
    a_bit  = (second_d == 6'd0) ? 1'b0 : stream[a_idx];

    unique case (second_d)
      6'd54:   b_bit = ~^{active_q.year_h, active_q.year_l};
      6'd55:   b_bit = ~^{active_q.month_h, active_q.month_l, active_q.day_h, active_q.day_l};
      6'd56:   b_bit = ~^active_q.dow;
      6'd57:   b_bit = ~^{active_q.hour_h, active_q.hour_l, active_q.minute_h, active_q.minute_l};
      default: b_bit = 1'b0;
    endcase

    if (second_d == 6'd0) begin
      carrier_d = (tenth_d >= 4'd5);
    end else begin
      unique case (tenth_d)
        4'd0:    carrier_d = 1'b0;
        4'd1:    carrier_d = ~a_bit;
        4'd2:    carrier_d = ~b_bit;
        default: carrier_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      tenth_q   <= 4'd0;
      second_q  <= 6'd0;
      active_q  <= '0;
      pending_q <= '0;
      pend_v_q  <= 1'b0;
      carrier_q <= 1'b1;
      valid_q   <= 1'b0;
      s00_q     <= 1'b0;
      minute_q  <= 1'b0;
      data_q    <= 2'b00;
    end else begin
      valid_q  <= 1'b0;
      s00_q    <= 1'b0;
      minute_q <= 1'b0;
      if (bus.tick_i) begin
        state_q   <= ST_RUN;
        tenth_q   <= tenth_d;
        second_q  <= second_d;
        carrier_q <= carrier_d;
        if (tenth_d == 4'd0) begin
          valid_q <= 1'b1;
          data_q  <= {b_bit, a_bit};
          s00_q   <= (second_d == 6'd0);
        end
        if (minute_start) begin
          active_q <= active_d;
          minute_q <= 1'b1;
        end
      end
      // A load on the minute tick lands in pending after the old pending was consumed.
      if (bus.load_i) begin
        pending_q <= field_in;
        pend_v_q  <= 1'b1;
      end else if (minute_start) begin
        pend_v_q <= 1'b0;
      end
    end
  end

  assign bus.carrier_o    = carrier_q;
  assign bus.second_o     = second_q;
  assign bus.bits_valid_o = valid_q;
  assign bus.bits_data_o  = data_q;
  assign bus.second_00_o  = s00_q;
  assign bus.minute_o     = minute_q;
  assign dbg_state_o      = (state_q == ST_RUN);

endmodule

// File: tb/tb_msf_time_encoder.sv
// Scoreboard bench for msf_time_encoder: a behavioural model predicts every slot's outputs.
module tb_msf_time_encoder;

  typedef struct packed {
    logic [3:0] year_h;
    logic [3:0] year_l;
    logic       month_h;
    logic [3:0] month_l;
    logic [1:0] day_h;
    logic [3:0] day_l;
    logic [2:0] dow;
    logic [1:0] hour_h;
    logic [3:0] hour_l;
    logic [2:0] minute_h;
    logic [3:0] minute_l;
  } frame_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dbg_state;

  msf_time_encoder_if bus();

  msf_time_encoder dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .bus        (bus),
    .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [11:0] exp_q[$];

  // model state
  bit         m_idle;
  int         m_tenth, m_sec;
  frame_t     m_act, m_pend;
  bit         m_pv;
  logic [1:0] m_data;
  logic       m_car;
  logic [11:0] last_got;

  logic       rec_a [60];
  logic       rec_b [60];
  logic [9:0] rec_car [60];

  function automatic logic model_a(input frame_t f, input int s);
    logic r;
    r = 1'b0;
    if (s >= 17 && s <= 20) r = f.year_h[20-s];
    else if (s >= 21 && s <= 24) r = f.year_l[24-s];
    else if (s == 25) r = f.month_h;
    else if (s >= 26 && s <= 29) r = f.month_l[29-s];
    else if (s >= 30 && s <= 31) r = f.day_h[31-s];
    else if (s >= 32 && s <= 35) r = f.day_l[35-s];
    else if (s >= 36 && s <= 38) r = f.dow[38-s];
    else if (s >= 39 && s <= 40) r = f.hour_h[40-s];
    else if (s >= 41 && s <= 44) r = f.hour_l[44-s];
    else if (s >= 45 && s <= 47) r = f.minute_h[47-s];
    else if (s >= 48 && s <= 51) r = f.minute_l[51-s];
    else if (s >= 53 && s <= 58) r = 1'b1;
    return r;
  endfunction

  function automatic logic model_b(input frame_t f, input int s);
    int n;
    n = -1;
    case (s)
      54: n = $countones({f.year_h, f.year_l});
      55: n = $countones({f.month_h, f.month_l, f.day_h, f.day_l});
      56: n = $countones(f.dow);
      57: n = $countones({f.hour_h, f.hour_l, f.minute_h, f.minute_l});
      default: n = -1;
    endcase
    return (n >= 0) && (n % 2 == 0);
  endfunction

  function automatic frame_t model_inc(input frame_t f);
    frame_t r;
    int m, h;
    r = f;
    m = f.minute_h * 10 + f.minute_l + 1;
    h = f.hour_h * 10 + f.hour_l;
    if (m == 60) begin
      m = 0;
      h = (h + 1) % 24;
    end
    r.minute_h = 3'(m / 10);
    r.minute_l = 4'(m % 10);
    r.hour_h   = 2'(h / 10);
    r.hour_l   = 4'(h % 10);
    return r;
  endfunction

  function automatic logic [31:0] rec_field(input int lo, input int hi);
    logic [31:0] r;
    r = '0;
    for (int i = lo; i <= hi; i++) r = {r[30:0], rec_a[i]};
    return r;
  endfunction

  task automatic set_fields(input frame_t f);
    bus.year_h_i   = f.year_h;
    bus.year_l_i   = f.year_l;
    bus.month_h_i  = f.month_h;
    bus.month_l_i  = f.month_l;
    bus.day_h_i    = f.day_h;
    bus.day_l_i    = f.day_l;
    bus.dow_i      = f.dow;
    bus.hour_h_i   = f.hour_h;
    bus.hour_l_i   = f.hour_l;
    bus.minute_h_i = f.minute_h;
    bus.minute_l_i = f.minute_l;
  endtask

  function automatic logic [11:0] sample_outputs();
    return {bus.minute_o, bus.second_00_o, bus.bits_valid_o, bus.bits_data_o,
            bus.second_o, bus.carrier_o};
  endfunction

  task automatic drive_tick(input bit with_load, input frame_t nf);
    logic [11:0] got, e;
    logic a, b;
    bit mev;
    @(negedge clk);
    bus.tick_i = 1'b1;
    bus.load_i = with_load;
    if (with_load) set_fields(nf);
    if (m_idle) begin
      m_idle = 1'b0;
      m_tenth = 0;
      m_sec = 0;
    end else if (m_tenth == 9) begin
      m_tenth = 0;
      m_sec = (m_sec == 59) ? 0 : m_sec + 1;
    end else begin
      m_tenth++;
    end
    mev = (m_tenth == 0) && (m_sec == 0);
    if (mev) begin
      if (m_pv) begin
        m_act = m_pend;
        m_pv = 1'b0;
      end else begin
        m_act = model_inc(m_act);
      end
    end
    if (with_load) begin
      m_pend = nf;
      m_pv = 1'b1;
    end
    a = model_a(m_act, m_sec);
    b = model_b(m_act, m_sec);
    if (m_sec == 0) m_car = (m_tenth >= 5);
    else if (m_tenth == 0) m_car = 1'b0;
    else if (m_tenth == 1) m_car = ~a;
    else if (m_tenth == 2) m_car = ~b;
    else m_car = 1'b1;
    if (m_tenth == 0) m_data = (m_sec == 0) ? 2'b00 : {b, a};
    exp_q.push_back({mev, mev, (m_tenth == 0), m_data, 6'(m_sec), m_car});

    @(posedge clk);
    #1;
    bus.tick_i = 1'b0;
    bus.load_i = 1'b0;
    got = sample_outputs();
    last_got = got;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL tick_scoreboard: queue empty, got %h", got);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        failures++;
        $display("FAIL tick_slot s%0d t%0d: got %h expected %h", m_sec, m_tenth, got, e);
      end
    end
    rec_car[m_sec][9-m_tenth] = bus.carrier_o;
    if (m_tenth == 0) begin
      rec_a[m_sec] = bus.bits_data_o[0];
      rec_b[m_sec] = bus.bits_data_o[1];
    end

    if ($urandom_range(0, 3) == 0) begin
      @(posedge clk);
      #1;
      got = sample_outputs();
      checks++;
      if (got !== {3'b000, m_data, 6'(m_sec), m_car}) begin
        failures++;
        $display("FAIL gap_hold: got %h expected %h", got, {3'b000, m_data, 6'(m_sec), m_car});
      end
    end
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) drive_tick(1'b0, '0);
  endtask

  task automatic do_load(input frame_t nf);
    logic [11:0] got;
    @(negedge clk);
    bus.load_i = 1'b1;
    set_fields(nf);
    m_pend = nf;
    m_pv = 1'b1;
    @(posedge clk);
    #1;
    bus.load_i = 1'b0;
    got = sample_outputs();
    checks++;
    if (got[11:9] !== 3'b000) begin
      failures++;
      $display("FAIL load_no_pulse: got %b expected 000", got[11:9]);
    end
  endtask

  task automatic do_reset();
    logic [11:0] got;
    @(negedge clk);
    rst_n = 1'b0;
    bus.tick_i = 1'b0;
    bus.load_i = 1'b0;
    @(posedge clk);
    #1;
    got = sample_outputs();
    checks++;
    if (got !== 12'b000_00_000000_1 || dbg_state !== 1'b0) begin
      failures++;
      $display("FAIL reset_values: got %h state %b expected 001 state 0", got, dbg_state);
    end
    m_idle = 1'b1;
    m_tenth = 0;
    m_sec = 0;
    m_act = '0;
    m_pend = '0;
    m_pv = 1'b0;
    m_data = 2'b00;
    m_car = 1'b1;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  localparam frame_t F_A    = '{4'h2, 4'h3, 1'b0, 4'h6, 2'h1, 4'h5, 3'h4, 2'h1, 4'h2, 3'h3, 4'h5};
  localparam frame_t F_2359 = '{4'h2, 4'h3, 1'b0, 4'h6, 2'h1, 4'h5, 3'h4, 2'h2, 4'h3, 3'h5, 4'h9};
  localparam frame_t F_1020 = '{4'h9, 4'h9, 1'b1, 4'h2, 2'h3, 4'h1, 3'h7, 2'h1, 4'h0, 3'h2, 4'h0};
  localparam frame_t F_1145 = '{4'h0, 4'h1, 1'b0, 4'h1, 2'h0, 4'h2, 3'h1, 2'h1, 4'h1, 3'h4, 4'h5};
  localparam frame_t F_BAD  = '{4'hF, 4'hA, 1'b1, 4'hF, 2'h3, 4'hC, 3'h7, 2'h3, 4'hF, 3'h7, 4'hF};

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_idle();
    logic [11:0] got;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      got = sample_outputs();
      checks++;
      if (got !== 12'b000_00_000000_1) begin
        failures++;
        $display("FAIL idle_no_tick: got %h expected 001", got);
      end
    end
  endtask

  task automatic test_first_tick();
    do_reset();
    drive_tick(1'b0, '0);
    check_val("first_tick_valid_s00", {30'd0, last_got[10:9]}, 32'd3);
    check_val("first_tick_second", {26'd0, last_got[6:1]}, 32'd0);
    check_val("first_tick_state", {31'd0, dbg_state}, 32'd1);
    run_ticks(9);
    check_val("second00_carrier", {22'd0, rec_car[0]}, {22'd0, 10'b0000011111});
  endtask

  task automatic test_full_minute();
    do_reset();
    do_load(F_A);
    run_ticks(600);
    check_val("a17_24_year", rec_field(17, 24), 32'b0010_0011);
    check_val("a36_38_dow", rec_field(36, 38), 32'b100);
    check_val("a39_51_time", rec_field(39, 51), 32'b01_0010_011_0101);
    check_val("b54_57_parity", {28'd0, rec_b[54], rec_b[55], rec_b[56], rec_b[57]}, 32'b0001);
    check_val("sec53_carrier", {22'd0, rec_car[53]}, {22'd0, 10'b0011111111});
  endtask

  task automatic test_rollover();
    do_reset();
    do_load(F_2359);
    run_ticks(600);
    check_val("time_2359", rec_field(39, 51), 32'b10_0011_101_1001);
    run_ticks(600);
    check_val("time_0000", rec_field(39, 51), 32'd0);
    check_val("date_kept", rec_field(17, 38), {10'd0, 8'h23, 1'b0, 4'h6, 2'h1, 4'h5, 3'h4});
  endtask

  task automatic test_load_at_minute();
    do_reset();
    do_load(F_1020);
    run_ticks(600);
    drive_tick(1'b1, F_1145);
    run_ticks(599);
    check_val("minute2_autoinc", rec_field(39, 51), 32'b01_0000_010_0001);
    run_ticks(600);
    check_val("minute3_loaded", rec_field(39, 51), 32'b01_0001_100_0101);
  endtask

  task automatic test_reset_mid();
    do_reset();
    run_ticks(303);
    do_load(F_A);
    do_reset();
    drive_tick(1'b0, '0);
    check_val("restart_slot", {20'd0, last_got}, {20'd0, 1'b1, 1'b1, 1'b1, 2'b00, 6'd0, 1'b0});
    run_ticks(599);
    check_val("restart_time", rec_field(39, 51), 32'd1);
    check_val("restart_year", rec_field(17, 24), 32'd0);
  endtask

  task automatic test_out_of_range();
    do_reset();
    do_load(F_BAD);
    run_ticks(600);
    check_val("bad_time_raw", rec_field(39, 51), {19'd0, 2'h3, 4'hF, 3'h7, 4'hF});
  endtask

  initial begin
    bus.tick_i = 1'b0;
    bus.load_i = 1'b0;
    set_fields('0);
    m_idle = 1'b1;
    m_tenth = 0;
    m_sec = 0;
    m_act = '0;
    m_pend = '0;
    m_pv = 1'b0;
    m_data = 2'b00;
    m_car = 1'b1;
    last_got = '0;
    repeat (2) @(posedge clk);
    test_reset();
    test_idle();
    test_first_tick();
    test_full_minute();
    test_rollover();
    test_load_at_minute();
    test_reset_mid();
    test_out_of_range();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
